// File: rtl/instr_fetch_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_seq_if
// Brief    : Memory-read and cpu-handoff bundle between fetch sequencer and cpu.
// Revision : 1.0  initial release
// ============================================================================
interface instr_fetch_seq_if #(
  parameter int ADDR_W = 8
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [15:0]       cpu_in;
  logic              cpu_load;
  logic              cpu_s;
  logic              cpu_w;

  modport master (
    output mem_rd, mem_addr, cpu_in, cpu_load, cpu_s,
    input  mem_rdata, cpu_w
  );

  modport slave (
    input  mem_rd, mem_addr, cpu_in, cpu_load, cpu_s,
    output mem_rdata, cpu_w
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_seq
// Brief    : PC-driven instruction fetch and cpu handoff with halt detection,
//            stall timeout and retired-instruction counting.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_seq #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  instr_fetch_seq_if.master  bus,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               err,
  output logic [15:0]        icount
);

  localparam logic [7:0] c_TCNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_MEMWAIT = 3'd2,
    S_LOAD    = 3'd3,
    S_START   = 3'd4,
    S_EXEC    = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [15:0]       r_icount;
  logic [7:0]        r_tcnt;
  logic              r_halted;
  logic              r_err;
  logic              w_is_halt;
  logic              w_retire;
  logic              w_timeout;

  // Opcode 3'b111 in the top bits marks a halt instruction.
  assign w_is_halt = (bus.mem_rdata[15:13] == 3'b111);
  assign w_retire  = (r_state == S_EXEC) && bus.cpu_w;
  assign w_timeout = (r_state == S_EXEC) && !bus.cpu_w && (r_tcnt == c_TCNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    bus.mem_rd   = 1'b0;
    bus.cpu_load = 1'b0;
    bus.cpu_s    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_rd = 1'b1;
        w_next     = S_MEMWAIT;
      end
      S_MEMWAIT: begin
        w_next = w_is_halt ? S_HALT : S_LOAD;
      end
      S_LOAD: begin
        bus.cpu_load = 1'b1;
        w_next       = S_START;
      end
      S_START: begin
        bus.cpu_s = 1'b1;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        // Completion wins over timeout when cpu_w arrives on the last allowed cycle.
        if (w_retire) begin
          w_next = run ? S_FETCH : S_IDLE;
        end else if (w_timeout) begin
          w_next = S_HALT;
        end
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_icount <= '0;
      r_tcnt   <= '0;
      r_halted <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_MEMWAIT: begin
          r_ir <= bus.mem_rdata;
          if (w_is_halt) r_halted <= 1'b1;
        end
        S_START: begin
          r_tcnt <= '0;
        end
        S_EXEC: begin
          r_tcnt <= r_tcnt + 8'd1;
          if (w_retire) begin
            r_pc <= r_pc + ADDR_W'(1);
            if (r_icount != 16'hFFFF) r_icount <= r_icount + 16'd1;
          end else if (w_timeout) begin
            r_err    <= 1'b1;
            r_halted <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr = r_pc;
  assign bus.cpu_in   = r_ir;
  assign pc           = r_pc;
  assign halted       = r_halted;
  assign err          = r_err;
  assign icount       = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_seq
// Brief    : Scoreboard bench for instr_fetch_seq with memory and cpu models.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_seq;

  localparam int            AW    = 2;
  localparam int            DEPTH = 1 << AW;
  localparam int            TO    = 6;
  localparam logic [AW-1:0] RPC   = 2'd1;

  typedef struct {
    bit          is_halt;
    logic [15:0] ir;
    int          pc;
    int          ic;
    bit          err;
    int          gap;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           run;
  logic [AW-1:0]  pc;
  logic           halted;
  logic           err;
  logic [15:0]    icount;

  instr_fetch_seq_if #(.ADDR_W(AW)) bus ();

  instr_fetch_seq #(.ADDR_W(AW), .RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .bus    (bus),
    .pc     (pc),
    .halted (halted),
    .err    (err),
    .icount (icount)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  int   dq[$];
  logic [15:0] mem [DEPTH];
  int   m_pc = int'(RPC);
  int   m_ic = 0;
  bit   m_halted = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Synchronous-read memory: data appears the cycle after mem_rd, junk otherwise.
  initial begin : mem_model
    logic        pend;
    logic [15:0] val;
    pend = 1'b0;
    val  = '0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd === 1'b1) begin
        pend = 1'b1;
        val  = mem[bus.mem_addr];
      end
      @(posedge clk);
      #1;
      bus.mem_rdata = pend ? val : 16'($urandom);
      pend = 1'b0;
    end
  end

  // cpu model: raises w on the d-th EXEC cycle after s; d==0 never answers.
  initial begin : cpu_model
    bit active;
    int ecnt;
    int d;
    active = 0; ecnt = 0; d = 1;
    bus.cpu_w = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.cpu_w = 1'b0;
      if (reset !== 1'b1) begin
        active = 0;
      end else if (bus.cpu_s === 1'b1) begin
        active = 1;
        ecnt   = 0;
        d      = (dq.size() != 0) ? dq.pop_front() : 1;
      end else if (active) begin
        ecnt++;
        if (ecnt == d) begin
          bus.cpu_w = 1'b1;
          active    = 0;
        end
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    logic        prev_h;
    int          load_cyc;
    int          s_cyc;
    logic [15:0] cur_ir;
    prev_h = 1'b0; load_cyc = -10; s_cyc = -100; cur_ir = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        prev_h = 1'b0;
      end else begin
        check("strobe_excl", ($countones({bus.mem_rd, bus.cpu_load, bus.cpu_s}) <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (bus.cpu_load === 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_load: cpu_in=%0h pc=%0d with nothing expected", bus.cpu_in, pc);
          end else begin
            e = exp_q.pop_front();
            check("evt_is_load", {31'd0, e.is_halt}, 32'd0);
            check("cpu_in", bus.cpu_in, e.ir);
            check("load_pc", pc, e.pc);
            check("load_icount", icount, e.ic);
            if (e.gap >= 0) check("load_gap", cyc - s_cyc, e.gap);
            cur_ir = e.ir;
          end
          load_cyc = cyc;
        end
        if (bus.cpu_s === 1'b1) begin
          check("s_after_load", cyc - load_cyc, 1);
          check("cpu_in_start", bus.cpu_in, cur_ir);
          s_cyc = cyc;
        end
        if (bus.cpu_w === 1'b1) check("cpu_in_exec_end", bus.cpu_in, cur_ir);
        if (halted === 1'b1 && prev_h !== 1'b1) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_halt: err=%0b pc=%0d with nothing expected", err, pc);
          end else begin
            e = exp_q.pop_front();
            check("evt_is_halt", {31'd0, e.is_halt}, 32'd1);
            check("halt_err", err, e.err);
            check("halt_pc", pc, e.pc);
            check("halt_icount", icount, e.ic);
            if (e.gap >= 0) check("halt_gap", cyc - s_cyc, e.gap);
          end
        end
        prev_h = halted;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    run = 1'b0;
    exp_q.delete();
    dq.delete();
    m_pc = int'(RPC); m_ic = 0; m_halted = 0;
    @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic fill_mem(input int halt_pct);
    logic [15:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = 16'($urandom);
      if (int'($urandom_range(0, 99)) < halt_pct) w[15:13] = 3'b111;
      else w[15:13] = 3'($urandom_range(0, 6));
      mem[i] = w;
    end
  endtask

  // Reference: walk memory from the model pc, one instruction per step.
  // dmode >= 0 fixes the cpu delay; -1 random 1..TO; -2 also allows a stall.
  task automatic episode(input int n, input int dmode);
    exp_t        e;
    logic [15:0] w;
    int d, prev_d, nload, seen, t;
    bit halts, first, exp_err;
    halts = 0; first = 1; nload = 0; prev_d = 0; exp_err = 0;
    for (int i = 0; i < n && !halts; i++) begin
      w = mem[m_pc];
      if (w[15:13] == 3'b111) begin
        e = '{1'b1, 16'h0, m_pc, m_ic, 1'b0, first ? -1 : prev_d + 3};
        exp_q.push_back(e);
        halts = 1;
      end else begin
        if (dmode >= 0) d = dmode;
        else if (dmode == -2 && $urandom_range(0, 7) == 0) d = 0;
        else d = int'($urandom_range(1, TO));
        e = '{1'b0, w, m_pc, m_ic, 1'b0, first ? -1 : prev_d + 3};
        exp_q.push_back(e);
        dq.push_back(d);
        nload++;
        if (d == 0) begin
          e = '{1'b1, 16'h0, m_pc, m_ic, 1'b1, TO + 1};
          exp_q.push_back(e);
          halts = 1; exp_err = 1;
        end else begin
          m_pc = (m_pc + 1) % DEPTH;
          if (m_ic != 65535) m_ic = m_ic + 1;
          prev_d = d;
        end
      end
      first = 0;
    end
    @(negedge clk);
    run = 1'b1;
    if (halts) begin
      t = 0;
      while (halted !== 1'b1 && t < 400) begin
        @(negedge clk);
        t++;
      end
      check("halt_reached", halted, 1);
      repeat (20) @(negedge clk);
      run = 1'b0;
    end else begin
      seen = 0; t = 0;
      while (seen < nload && t < 400) begin
        @(negedge clk);
        t++;
        if (bus.cpu_s === 1'b1) seen++;
      end
      run = 1'b0;
      check("starts_seen", seen, nload);
      repeat (TO + 8) @(negedge clk);
    end
    check("ep_pc", pc, m_pc);
    check("ep_icount", icount, m_ic);
    check("ep_halted", halted, {31'd0, halts});
    check("ep_err", err, {31'd0, exp_err});
    check("ep_drained", exp_q.size(), 0);
    m_halted = halts;
  endtask

  // Reset k cycles after FETCH: 1=MEMWAIT, 2=LOAD, 3=START, 4=EXEC.
  task automatic reset_phase(input int k);
    exp_t e;
    int t;
    if (k >= 3) begin
      e = '{1'b0, mem[m_pc], m_pc, m_ic, 1'b0, -1};
      exp_q.push_back(e);
      dq.push_back(TO);
    end
    @(negedge clk);
    run = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.mem_rd !== 1'b1 && t < 50);
    check("fetch_seen", bus.mem_rd, 1);
    repeat (k) @(posedge clk);
    #2 reset = 1'b0;
    run = 1'b0;
    #1;
    check("rst_strobes", {29'd0, bus.mem_rd, bus.cpu_load, bus.cpu_s}, 0);
    check("rst_pc", pc, RPC);
    check("rst_icount", icount, 0);
    check("rst_halted", halted, 0);
    exp_q.delete();
    dq.delete();
    m_pc = int'(RPC); m_ic = 0; m_halted = 0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", {29'd0, bus.mem_rd, bus.cpu_load, bus.cpu_s}, 0);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1;
    run   = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #3 reset = 1'b0;
    #1;
    check("res_strobes", {29'd0, bus.mem_rd, bus.cpu_load, bus.cpu_s}, 0);
    check("res_pc", pc, RPC);
    check("res_icount", icount, 0);
    check("res_halted", halted, 0);
    check("res_err", err, 0);
    check("res_cpu_in", bus.cpu_in, 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_pc", pc, RPC);
      check("idle_icount", icount, 0);
      check("idle_strobes", {29'd0, bus.mem_rd, bus.cpu_load, bus.cpu_s}, 0);
    end

    // Halt after one instruction; cpu answers on its 2nd EXEC cycle.
    fill_mem(0);
    mem[RPC]                   = 16'hD105;
    mem[(int'(RPC) + 1) % DEPTH] = 16'hE000;
    episode(3, 2);

    // Run dropped mid-instruction, resumed, and pc wrap.
    do_reset();
    fill_mem(0);
    episode(1, -1);
    episode(3, -1);
    episode(4, -1);

    // cpu answering on the last allowed cycle, then a stall to timeout.
    do_reset();
    fill_mem(0);
    episode(2, TO);
    episode(1, 0);

    for (int r = 0; r < 8; r++) begin
      if (m_halted || r == 0) do_reset();
      fill_mem(15);
      episode(int'($urandom_range(1, 6)), -2);
    end

    for (int k = 1; k <= 4; k++) begin
      do_reset();
      fill_mem(0);
      episode(2, -1);
      reset_phase(k);
    end

    check("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
